// File: rtl/fp_align_pkg.sv
// fp_align_pkg: shared widths, helper and stage-1 bundle for fp_align_pipe.
// The stage-1 struct is sized for the widest supported format; the pipe uses the low bits.
package fp_align_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int GRS_W     = 3;
    localparam int EXP_MAX_W = 16;
    localparam int MAN_MAX_W = 64;

    // Aligned mantissa width: hidden bit + fraction + guard/round/sticky.
    function automatic int aligned_w(int man_w);
        return man_w + GRS_W + 1;
    endfunction

    typedef struct packed {
        logic [MAN_MAX_W:0]   man_big;
        logic [MAN_MAX_W:0]   man_small;
        logic [EXP_MAX_W-1:0] exp_big;
        logic [EXP_MAX_W-1:0] diff;
        logic                 sign_big;
        logic                 sign_small;
        logic                 swapped;
        logic                 special;
    } s1_t;

endpackage

// File: rtl/fp_align_pipe_if.sv
// fp_align_pipe_if: operand-in / aligned-result-out valid/ready bundle.
// slave = aligner view, master = producer/consumer view.
interface fp_align_pipe_if
    import fp_align_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
);
    localparam int AW = aligned_w(MAN_W);

    logic             in_valid;
    logic             in_ready;
    logic             sign_a;
    logic             sign_b;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W-1:0] man_a;
    logic [MAN_W-1:0] man_b;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] exp_out;
    logic [AW-1:0]    man_big;
    logic [AW-1:0]    man_small;
    logic             sign_big;
    logic             sign_small;
    logic             swapped;
    logic             special;

    modport slave (
        input  in_valid, sign_a, sign_b, exp_a, exp_b,
        input  man_a, man_b, out_ready,
        output in_ready, out_valid, exp_out, man_big,
        output man_small, sign_big, sign_small, swapped, special
    );

    modport master (
        output in_valid, sign_a, sign_b, exp_a, exp_b,
        output man_a, man_b, out_ready,
        input  in_ready, out_valid, exp_out, man_big,
        input  man_small, sign_big, sign_small, swapped, special
    );

endinterface

// File: rtl/fp_align_pipe_shift_sticky.sv
// fp_shift_sticky: right shift of {hidden, frac, GRS} with sticky collapse.
// Ports: man_i {hidden,frac}, diff_i shift amount, man_o aligned mantissa.
module fp_shift_sticky
    import fp_align_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic [MAN_W:0]              man_i,
    input  logic [EXP_W-1:0]            diff_i,
    output logic [aligned_w(MAN_W)-1:0] man_o
);
    localparam int AW = aligned_w(MAN_W);

    logic [AW-1:0] ext;
    logic [AW-1:0] shifted;
    logic [AW-1:0] lost_mask;
    logic [31:0]   diff_w;

    always_comb begin
        ext       = {man_i, {GRS_W{1'b0}}};
        shifted   = ext >> diff_i;
        lost_mask = ~({AW{1'b1}} << diff_i);
        diff_w    = {{(32-EXP_W){1'b0}}, diff_i};
        if (diff_w >= 32'(AW)) begin
            // Everything is shifted out; only stickiness survives.
            man_o = {{(AW-1){1'b0}}, |man_i};
        end else begin
            man_o = {shifted[AW-1:1],
                     shifted[0] | (|(ext & lost_mask))};
        end
    end

endmodule

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: 2-stage FP adder operand aligner (compare/swap, then shift/sticky).
// Ports: clk, reset (sync, high), io (fp_align_pipe_if.slave). Option: FP_ALIGN_SUBNORMAL_EN.
module fp_align_pipe
    import fp_align_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic            clk,
    input  logic            reset,
    fp_align_pipe_if.slave  io
);
    localparam int AW = aligned_w(MAN_W);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic             ha, hb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    logic             a_big;
    logic             adv1, adv2;
    logic             unused_s1;

    s1_t              s1_d, s1_q;
    logic             s1_valid_q;

    logic [AW-1:0]    shifted;
    logic             s2_valid_q;
    logic [EXP_W-1:0] exp_q;
    logic [AW-1:0]    man_big_q;
    logic [AW-1:0]    man_small_q;
    logic             sign_big_q, sign_small_q;
    logic             swapped_q, special_q;

    always_comb begin
`ifdef FP_ALIGN_SUBNORMAL_EN
        ha = (io.exp_a != '0);
        hb = (io.exp_b != '0);
        ea = ha ? io.exp_a : EXP_W'(1);
        eb = hb ? io.exp_b : EXP_W'(1);
`else
        ha = 1'b1;
        hb = 1'b1;
        ea = io.exp_a;
        eb = io.exp_b;
`endif
        ma = {ha, io.man_a};
        mb = {hb, io.man_b};
        // Full-mantissa compare so a subnormal never beats a normal on a tie.
        a_big = (ea > eb) || ((ea == eb) && (ma >= mb));

        s1_d = '0;
        s1_d.man_big[MAN_W:0]   = a_big ? ma : mb;
        s1_d.man_small[MAN_W:0] = a_big ? mb : ma;
        s1_d.exp_big[EXP_W-1:0] = a_big ? ea : eb;
        s1_d.diff[EXP_W-1:0]    = a_big ? (ea - eb) : (eb - ea);
        s1_d.sign_big   = a_big ? io.sign_a : io.sign_b;
        s1_d.sign_small = a_big ? io.sign_b : io.sign_a;
        s1_d.swapped    = !a_big;
        s1_d.special    = (io.exp_a == EXP_ONES) ||
                          (io.exp_b == EXP_ONES);
    end

    assign adv2        = !s2_valid_q || io.out_ready;
    assign adv1        = !s1_valid_q || adv2;
    assign io.in_ready = adv1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (adv1) begin
            s1_valid_q <= io.in_valid;
            if (io.in_valid) s1_q <= s1_d;
        end
    end

    fp_shift_sticky #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_shift (
        .man_i  (s1_q.man_small[MAN_W:0]),
        .diff_i (s1_q.diff[EXP_W-1:0]),
        .man_o  (shifted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q   <= 1'b0;
            exp_q        <= '0;
            man_big_q    <= '0;
            man_small_q  <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swapped_q    <= 1'b0;
            special_q    <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                exp_q        <= s1_q.exp_big[EXP_W-1:0];
                man_big_q    <= {s1_q.man_big[MAN_W:0], {GRS_W{1'b0}}};
                man_small_q  <= shifted;
                sign_big_q   <= s1_q.sign_big;
                sign_small_q <= s1_q.sign_small;
                swapped_q    <= s1_q.swapped;
                special_q    <= s1_q.special;
            end
        end
    end

    // Upper struct bits exist only for wider formats.
    assign unused_s1 = ^s1_q;

    assign io.out_valid  = s2_valid_q;
    assign io.exp_out    = exp_q;
    assign io.man_big    = man_big_q;
    assign io.man_small  = man_small_q;
    assign io.sign_big   = sign_big_q;
    assign io.sign_small = sign_small_q;
    assign io.swapped    = swapped_q;
    assign io.special    = special_q;

endmodule
